// File: rtl/mem_loader_pkg.sv
// Shared definitions for the memory loader: controller state encodings.
package mem_loader_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE       = 3'd0,
      ST_WAIT_DATA  = 3'd1,
      ST_WRITE      = 3'd2,
      ST_CHECK_LAST = 3'd3,
      ST_END        = 3'd4
   } state_t;

   // True for the states in which a load is in progress.
   function automatic logic state_is_busy(input state_t s);
      return (s == ST_WAIT_DATA) || (s == ST_WRITE) || (s == ST_CHECK_LAST);
   endfunction

endpackage

// File: rtl/mem_loader_datapath.sv
// Loader datapath: write address counter, data register, last flag and
// word counter, plus the end-of-memory comparator used by the controller.
module mem_loader_datapath
   import mem_loader_pkg::*;
#(
   parameter int AW      = 4,
   parameter int DW      = 8,
   parameter int MAXADDR = 2**AW-1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en_addr,
   input  logic          clr_addr,
   input  logic          en_mdr,
   input  logic          inc_count,
   input  logic [DW-1:0] in_data,
   input  logic          in_last,
   output logic          last_q,
   output logic          addr_eq_max,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic [AW:0]   count
);

   localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
   localparam logic [AW:0]   COUNT_ONE = (AW+1)'(1);
   localparam logic [AW-1:0] ADDR_MAX  = AW'(MAXADDR);

   logic [AW-1:0] addr_q,  addr_d;
   logic [DW-1:0] mdr_q,   mdr_d;
   logic          last_d;
   logic [AW:0]   count_q, count_d;

   // Next-value logic; a clear from the controller wins over an increment.
   always_comb begin
      addr_d  = addr_q;
      mdr_d   = mdr_q;
      last_d  = last_q;
      count_d = count_q;
      if (clr_addr) begin
         addr_d  = '0;
         count_d = '0;
      end else begin
         if (en_addr) begin
            addr_d = addr_q + ADDR_ONE;
         end
         if (inc_count) begin
            count_d = count_q + COUNT_ONE;
         end
      end
      if (en_mdr) begin
         mdr_d  = in_data;
         last_d = in_last;
      end
   end

   // Datapath registers, cleared asynchronously so outputs read 0 at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q  <= '0;
         mdr_q   <= '0;
         last_q  <= 1'b0;
         count_q <= '0;
      end else begin
         addr_q  <= addr_d;
         mdr_q   <= mdr_d;
         last_q  <= last_d;
         count_q <= count_d;
      end
   end

   assign addr_eq_max = (addr_q == ADDR_MAX);
   assign mem_addr    = addr_q;
   assign mem_wdata   = mdr_q;
   assign count       = count_q;

endmodule

// File: rtl/mem_loader.sv
// Memory loader top: controller FSM that accepts words over valid/ready and
// writes them to consecutive addresses, driving the datapath sub-module.
module mem_loader
   import mem_loader_pkg::*;
#(
   parameter int AW      = 4,
   parameter int DW      = 8,
   parameter int MAXADDR = 2**AW-1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   input  logic          in_last,
   output logic          in_ready,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          busy,
   output logic          done,
   output logic [AW:0]   count
);

   state_t state_q, state_d;

   logic en_addr;
   logic clr_addr;
   logic en_mdr;
   logic inc_count;
   logic last_q;
   logic addr_eq_max;

   // State register; reset lands in IDLE immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state, datapath enables and Moore control outputs.
   always_comb begin
      state_d   = state_q;
      en_addr   = 1'b0;
      clr_addr  = 1'b0;
      en_mdr    = 1'b0;
      inc_count = 1'b0;
      in_ready  = 1'b0;
      mem_we    = 1'b0;
      done      = 1'b0;
      busy      = state_is_busy(state_q);
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               clr_addr = 1'b1;
               state_d  = ST_WAIT_DATA;
            end
         end
         ST_WAIT_DATA: begin
            in_ready = 1'b1;
            if (in_valid) begin
               en_mdr  = 1'b1;
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            mem_we    = 1'b1;
            inc_count = 1'b1;
            state_d   = ST_CHECK_LAST;
         end
         ST_CHECK_LAST: begin
            if (last_q || addr_eq_max) begin
               state_d = ST_END;
            end else begin
               en_addr = 1'b1;
               state_d = ST_WAIT_DATA;
            end
         end
         ST_END: begin
            done = 1'b1;
            if (start) begin
               clr_addr = 1'b1;
               state_d  = ST_WAIT_DATA;
            end
         end
         default: begin
            busy    = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   mem_loader_datapath #(
      .AW      (AW),
      .DW      (DW),
      .MAXADDR (MAXADDR)
   ) u_datapath (
      .clk         (clk),
      .reset       (reset),
      .en_addr     (en_addr),
      .clr_addr    (clr_addr),
      .en_mdr      (en_mdr),
      .inc_count   (inc_count),
      .in_data     (in_data),
      .in_last     (in_last),
      .last_q      (last_q),
      .addr_eq_max (addr_eq_max),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .count       (count)
   );

endmodule

// File: tb/tb_mem_loader.sv
// Directed testbench for mem_loader with AW=2, DW=8, MAXADDR=3.
module tb_mem_loader;

   localparam int AW = 2;
   localparam int DW = 8;

   logic          clk;
   logic          reset;
   logic          start;
   logic          inValid;
   logic [DW-1:0] inData;
   logic          inLast;
   logic          inReady;
   logic          memWe;
   logic [AW-1:0] memAddr;
   logic [DW-1:0] memWdata;
   logic          busy;
   logic          done;
   logic [AW:0]   count;

   int vectorCount = 0;
   int missCount   = 0;
   int writeCount  = 0;
   int logAddr[$];
   int logData[$];

   mem_loader #(
      .AW      (AW),
      .DW      (DW),
      .MAXADDR (3)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .in_valid  (inValid),
      .in_data   (inData),
      .in_last   (inLast),
      .in_ready  (inReady),
      .mem_we    (memWe),
      .mem_addr  (memAddr),
      .mem_wdata (memWdata),
      .busy      (busy),
      .done      (done),
      .count     (count)
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Records every memory write seen at a clock edge.
   always @(posedge clk) begin
      if (memWe === 1'b1) begin
         logAddr.push_back(int'(memAddr));
         logData.push_back(int'(memWdata));
         writeCount++;
      end
   end

   // Hard stop in case something hangs.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      vectorCount++;
      if (actual !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Drive inputs, then advance past the next rising edge.
   task automatic applyStimulus(input logic s, input logic v, input logic [DW-1:0] d, input logic l);
      start   = s;
      inValid = v;
      inData  = d;
      inLast  = l;
      @(posedge clk);
      #1;
   endtask

   // Wait for in_ready, transfer one word, check the write cycle; ends in CHECK_LAST.
   task automatic sendWord(input logic [DW-1:0] d, input logic l, input int expAddr);
      for (int i = 0; i < 50 && inReady !== 1'b1; i++) begin
         applyStimulus(1'b0, 1'b0, '0, 1'b0);
      end
      checkOutput("ready before word", 32'(inReady), 32'd1);
      applyStimulus(1'b0, 1'b1, d, l);
      checkOutput("write we", 32'(memWe), 32'd1);
      checkOutput("write addr", 32'(memAddr), 32'(expAddr));
      checkOutput("write data", 32'(memWdata), 32'(d));
      applyStimulus(1'b0, 1'b0, '0, 1'b0);
      checkOutput("we single cycle", 32'(memWe), 32'd0);
   endtask

   task automatic checkLog(input int idx, input int a, input int d);
      checkOutput("log addr", 32'(logAddr[idx]), 32'(a));
      checkOutput("log data", 32'(logData[idx]), 32'(d));
   endtask

   initial begin
      int acc;
      int base;
      logic fire;
      logic [DW-1:0] word;

      reset   = 1'b0;
      start   = 1'b0;
      inValid = 1'b0;
      inData  = '0;
      inLast  = 1'b0;
      #1 reset = 1'b1;
      #1;
      checkOutput("reset in_ready", 32'(inReady), 32'd0);
      checkOutput("reset mem_we", 32'(memWe), 32'd0);
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset done", 32'(done), 32'd0);
      checkOutput("reset count", 32'(count), 32'd0);
      checkOutput("reset addr", 32'(memAddr), 32'd0);
      @(posedge clk);
      #3 reset = 1'b0;
      @(posedge clk);
      #1;

      // Idle with in_valid high but no start: nothing happens.
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 1'b1, 8'hEE, 1'b1);
         checkOutput("idle in_ready", 32'(inReady), 32'd0);
         checkOutput("idle done", 32'(done), 32'd0);
      end
      checkOutput("idle count", 32'(count), 32'd0);
      checkOutput("idle writes", 32'(writeCount), 32'd0);

      // Three words, last on the third.
      applyStimulus(1'b1, 1'b0, '0, 1'b0);
      checkOutput("start busy", 32'(busy), 32'd1);
      sendWord(8'h11, 1'b0, 0);
      sendWord(8'h22, 1'b0, 1);
      sendWord(8'h33, 1'b1, 2);
      applyStimulus(1'b0, 1'b0, '0, 1'b0);
      checkOutput("t2 done", 32'(done), 32'd1);
      checkOutput("t2 count", 32'(count), 32'd3);
      checkOutput("t2 addr held", 32'(memAddr), 32'd2);
      checkOutput("t2 writes", 32'(writeCount), 32'd3);
      checkLog(0, 0, 'h11);
      checkLog(1, 1, 'h22);
      checkLog(2, 2, 'h33);

      // Five words offered with in_valid always high and no last: stops at MAXADDR.
      base = writeCount;
      applyStimulus(1'b1, 1'b1, 8'hA0, 1'b0);
      checkOutput("t3 wait", 32'(inReady), 32'd1);
      acc = 0;
      for (int i = 0; i < 20; i++) begin
         fire = inReady;
         word = 8'hA0 + 8'(acc);
         applyStimulus(1'b0, 1'b1, word, 1'b0);
         if (fire) acc++;
      end
      checkOutput("t3 accepted", 32'(acc), 32'd4);
      checkOutput("t3 done", 32'(done), 32'd1);
      checkOutput("t3 count", 32'(count), 32'd4);
      checkOutput("t3 addr", 32'(memAddr), 32'd3);
      checkOutput("t3 in_ready", 32'(inReady), 32'd0);
      checkOutput("t3 writes", 32'(writeCount - base), 32'd4);
      for (int i = 0; i < 4; i++) begin
         checkLog(base + i, i, 'hA0 + i);
      end

      // Back-pressure: ten idle cycles in WAIT_DATA, then one last word.
      base = writeCount;
      applyStimulus(1'b1, 1'b0, '0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b0, 1'b0, 8'h5A, 1'b0);
         checkOutput("bp in_ready", 32'(inReady), 32'd1);
      end
      checkOutput("bp no write", 32'(writeCount - base), 32'd0);
      applyStimulus(1'b0, 1'b1, 8'h7F, 1'b1);
      checkOutput("bp we", 32'(memWe), 32'd1);
      checkOutput("bp addr", 32'(memAddr), 32'd0);
      checkOutput("bp data", 32'(memWdata), 32'h7F);
      applyStimulus(1'b0, 1'b0, '0, 1'b0);
      applyStimulus(1'b0, 1'b0, '0, 1'b0);
      checkOutput("bp done", 32'(done), 32'd1);
      checkOutput("bp count", 32'(count), 32'd1);
      checkOutput("bp writes", 32'(writeCount - base), 32'd1);

      // Reset in the middle of the WRITE of 0x22 at address 1.
      base = writeCount;
      applyStimulus(1'b1, 1'b0, '0, 1'b0);
      sendWord(8'h11, 1'b0, 0);
      applyStimulus(1'b0, 1'b0, '0, 1'b0);
      applyStimulus(1'b0, 1'b1, 8'h22, 1'b0);
      checkOutput("rw we", 32'(memWe), 32'd1);
      checkOutput("rw addr", 32'(memAddr), 32'd1);
      #2 reset = 1'b1;
      #1;
      checkOutput("rw we drop", 32'(memWe), 32'd0);
      checkOutput("rw busy drop", 32'(busy), 32'd0);
      checkOutput("rw ready drop", 32'(inReady), 32'd0);
      checkOutput("rw count", 32'(count), 32'd0);
      checkOutput("rw addr clr", 32'(memAddr), 32'd0);
      #2 reset = 1'b0;
      // start and in_valid together in IDLE: only start takes effect.
      applyStimulus(1'b1, 1'b1, 8'h99, 1'b0);
      checkOutput("sv in_ready", 32'(inReady), 32'd1);
      checkOutput("sv no we", 32'(memWe), 32'd0);
      applyStimulus(1'b0, 1'b0, '0, 1'b0);
      checkOutput("sv still wait", 32'(inReady), 32'd1);
      checkOutput("rw aborted", 32'(writeCount - base), 32'd1);
      sendWord(8'h33, 1'b1, 0);
      applyStimulus(1'b0, 1'b0, '0, 1'b0);
      checkOutput("rw restart count", 32'(count), 32'd1);
      checkLog(writeCount - 1, 0, 'h33);

      // Load three words, with start ignored while busy.
      applyStimulus(1'b1, 1'b0, '0, 1'b0);
      sendWord(8'h01, 1'b0, 0);
      sendWord(8'h02, 1'b0, 1);
      applyStimulus(1'b1, 1'b0, '0, 1'b0);
      checkOutput("busy start addr", 32'(memAddr), 32'd2);
      checkOutput("busy start count", 32'(count), 32'd2);
      checkOutput("busy start ready", 32'(inReady), 32'd1);
      sendWord(8'h03, 1'b1, 2);
      applyStimulus(1'b0, 1'b0, '0, 1'b0);
      checkOutput("ra end count", 32'(count), 32'd3);
      checkOutput("ra end done", 32'(done), 32'd1);

      // Re-arm from END.
      applyStimulus(1'b1, 1'b0, '0, 1'b0);
      checkOutput("ra count", 32'(count), 32'd0);
      checkOutput("ra addr", 32'(memAddr), 32'd0);
      checkOutput("ra in_ready", 32'(inReady), 32'd1);
      sendWord(8'h55, 1'b1, 0);
      applyStimulus(1'b0, 1'b0, '0, 1'b0);
      checkOutput("ra done", 32'(done), 32'd1);
      checkOutput("ra final count", 32'(count), 32'd1);
      checkLog(writeCount - 1, 0, 'h55);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule

// File: doc/mem_loader.md
Name: mem_loader

Overview:
- Writer-side companion to the max-finder: fills the word-addressed data memory with a stream of words before the max-finder scans it.
- Accepts words over a valid/ready input stream and writes them to consecutive addresses starting at 0.
- Stops on a `last`-tagged word or when MAXADDR has been written, then reports the number of words stored.
- Split into a controller FSM plus a small datapath: address counter, data register, last flag and word counter.

Parameters:
- AW, 4, memory address width.
- DW, 8, memory data width.
- MAXADDR, 2**AW-1, highest writable address. Loading stops after writing here.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin a load. Sampled only in IDLE and END.
- in_valid  input  1  in_data/in_last are valid.
- in_data  input  DW  word to store.
- in_last  input  1  marks the final word of the load.
- in_ready  output  1  block can accept a word this cycle.
- mem_we  output  1  memory write enable, one cycle per word.
- mem_addr  output  AW  write address.
- mem_wdata  output  DW  write data.
- busy  output  1  load in progress (WAIT_DATA, WRITE, CHECK_LAST).
- done  output  1  load complete (END).
- count  output  AW+1  words written in the current or last load. Range 0..2**AW.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - State goes to IDLE, and addr, mdr, last_q and count clear to 0.
  - All outputs read 0 immediately, without waiting for a clock edge.
- Input handshake:
  - A word transfers on a rising clk edge where in_valid && in_ready.
  - in_ready is a Moore output, high only in WAIT_DATA.
  - in_valid in any other state is ignored; nothing is captured.
- Control outputs (in_ready, mem_we, busy, done) decode combinationally from state only.
- Data outputs are registers: mem_addr = addr, mem_wdata = mdr.
- States:
  - IDLE: all control outputs 0. On start, clear addr and count, go to WAIT_DATA. Otherwise stay.
  - WAIT_DATA: in_ready=1. On a transfer, mdr <= in_data, last_q <= in_last, go to WRITE. Otherwise stay; waiting is unbounded.
  - WRITE: mem_we=1 for exactly this cycle, with mem_addr=addr and mem_wdata=mdr. count <= count+1. Go to CHECK_LAST.
  - CHECK_LAST: if last_q or addr==MAXADDR, go to END with addr held. Otherwise addr <= addr+1 and go to WAIT_DATA.
  - END: done=1, count held, addr holds the last written address. On start, clear addr and count, go to WAIT_DATA. Otherwise stay.
- Throughput: at most one word per 3 cycles.
  - Latency from the accepting edge to the mem_we cycle is 1 cycle.
- Boundaries:
  - No address wrap. The word written at MAXADDR ends the load even when in_last=0, and count = 2**AW.
  - in_last on the word at MAXADDR: END, the same outcome.
  - start is ignored while busy.
  - start held high through END re-arms on the next edge.
  - start and in_valid in the same IDLE cycle: only start takes effect. The word is not captured; in_ready was 0.
  - Reset during WRITE aborts the write asynchronously; mem_we drops immediately. Memory contents are not cleared.
  - Illegal state encodings fall to IDLE.

Decomposition:
- Shared package holds the state encodings IDLE=3'd0, WAIT_DATA=3'd1, WRITE=3'd2, CHECK_LAST=3'd3, END=3'd4.
- Controller:
  - Contains the FSM.
  - Drives the datapath enables en_addr, clr_addr, en_mdr, inc_count.
  - Drives in_ready, mem_we, busy and done.
  - Takes last_q and addr_eq_max from the datapath.
- One sub-module, mem_loader_datapath:
  - Registers: addr, mdr, last_q, count.
  - Comparator: addr==MAXADDR.
  - Width rules: addr is AW bits; count is AW+1 bits, unsigned, no saturation needed.

Test Plan (AW=2, DW=8, MAXADDR=3 unless noted):
- Reset then idle: in_valid=1 with no start -> in_ready=0, mem_we never rises, count=0, done=0.
- start, then words 0x11, 0x22, 0x33 with in_last on 0x33 -> writes (0,0x11), (1,0x22), (2,0x33), each with a single-cycle mem_we; done=1, count=3, addr 3 never written.
- start, then 5 words 0xA0..0xA4 with no in_last, in_valid always high -> exactly 4 writes at addresses 0..3, ends at address 3, count=4; 0xA4 never accepted (in_ready low in END).
- Back-pressure: in_valid low for 10 cycles in WAIT_DATA, then 0x7F with in_last -> in_ready stays high, no write until the transfer; one write (0,0x7F) 1 cycle later; count=1.
- Reset asserted mid-cycle while in WRITE of 0x22 at address 1 -> mem_we, busy and in_ready drop before the next edge; state IDLE, count=0; a following start restarts at address 0.
- Re-arm: in END with count=3, pulse start -> count=0, addr=0, in_ready=1 next cycle; new word 0x55 with in_last written to address 0.
